j_img_index_counter: RTL and testbench
======================================

// Module: j_img_index_counter
// PURPOSE
//  Parametrised 2-D raster index generator for image traversal: column counter nested in a row counter.
//  Sequenced by a start/busy/done FSM.
//  Sits between the image-fetch controller (drives count_enable per pixel) and SRAM address generation.
//  Replaces separate per-axis row/column counters with one frame-level block.
// PARAMETERS
//  IDX_W   13         width of column/row indices and img_width/img_height (max dimension 2**IDX_W-1)
//  ADDR_W  2*IDX_W    width of linear pixel address (used only with J_LINEAR_ADDR_EN)
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  n_rst         in   1       asynchronous active-low reset
//  clear         in   1       synchronous abort/clear, priority over all other inputs
//  start         in   1       begin a frame; config latched on this cycle (IDLE only)
//  img_width     in   IDX_W   pixels per row, sampled with start
//  img_height    in   IDX_W   rows per frame, sampled with start
//  count_enable  in   1       advance one pixel (RUN only)
//  col           out  IDX_W   current column index
//  row           out  IDX_W   current row index
//  line_end      out  1       1-cycle pulse: row just advanced (col wrapped to 0)
//  frame_done    out  1       1-cycle pulse: last pixel of frame consumed
//  busy          out  1       high while state==RUN
//  cfg_err       out  1       1-cycle pulse: start rejected (width or height == 0)
//  lin_addr      out  ADDR_W  row*width+col (only with J_LINEAR_ADDR_EN)
// BEHAVIOUR
//  - Reset (n_rst=0, async): state IDLE; col,row,lin_addr=0; line_end,frame_done,busy,cfg_err=0; latched cfg=0.
//  - clear=1 at an edge: same values as reset, synchronously. Overrides start/count_enable in the same cycle.
//  - All outputs registered; count_enable at edge k is reflected in col/row/flags after edge k (latency 1).
//  - FSM IDLE -> RUN:
//    - start=1 with img_width!=0 and img_height!=0; latch wmax=img_width-1, hmax=img_height-1.
//    - col,row cleared to 0; busy=1 next cycle.
//  - FSM IDLE, start with zero dimension: remain IDLE, cfg_err=1 for one cycle, counters untouched.
//  - FSM RUN, count_enable=1:
//    - col<wmax: col+1.
//    - col==wmax, row<hmax: col->0, row+1, line_end=1.
//    - col==wmax, row==hmax: col->0, row->0, line_end=1, frame_done=1, -> DONE.
//  - FSM DONE (one cycle): busy=0, -> IDLE unconditionally; start in DONE ignored.
//  - start while RUN ignored (no relatch). count_enable in IDLE/DONE ignored.
//  - Flags are pulses: cleared the cycle after assertion, also when count_enable low.
//  - width==1: every enable wraps (line_end each pixel).
//  - width==1 && height==1: first enable gives frame_done.
//  - Dimension 2**IDX_W-1 (all ones) fully supported; compare against latched max, no overflow.
//  - img_width/img_height changes after start have no effect until next frame.
// CONFIGURATION
//  - J_LINEAR_ADDR_EN defined: lin_addr port present, kept incrementally (no multiplier).
//    - lin_addr+1 per enable; ->0 on frame wrap; 0 on reset/clear/start.
//    - Invariant lin_addr == row*img_width+col.
//  - Undefined: lin_addr port and its register absent; all other behaviour identical.
// STRUCTURE
//  - Package j_img_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} j_idx_state_t.
//  - Package j_img_pkg: localparam J_IDX_W_DEFAULT = 13.
//  - Sub-module j_rollover_counter #(W): clear, count_enable, rollover_val, value, wrap.
//    - Instanced twice (column; row enabled by column wrap).
//    - wrap is combinational (value==rollover_val && count_enable), used for chaining.
//  - Top holds FSM, config latches, pulse registers, optional linear address.
// TESTING
//  - Reset mid-frame: run W=10,H=4, 13 enables, drop n_rst async -> col=row=0, busy=0 immediately, all flags 0.
//  - Full frame W=10,H=4, enable every 4th cycle:
//    - col 0..9 per row; line_end after enables 10,20,30,40.
//    - frame_done only after enable 40; busy falls with DONE, then IDLE.
//  - Degenerate W=1,H=1: start, one enable -> line_end=1, frame_done=1 same cycle, col=row=0.
//  - cfg_err: start with W=0,H=5 -> cfg_err pulse 1 cycle, busy stays 0.
//    - Subsequent enables leave col=row=0.
//  - clear vs enable: W=100,H=3, col=57; assert clear+count_enable together -> col=row=0, IDLE, no line_end.
//  - Max dim W=8191,H=2 (IDX_W=13):
//    - 8190 enables -> col=8190, row=0; next -> col=0,row=1,line_end.
//    - With J_LINEAR_ADDR_EN, lin_addr=8191 there.

Source files
------------

// File: rtl/j_img_index_counter_pkg.sv
// Shared types and defaults for the 2-D raster index generator.
package j_img_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} j_idx_state_t;

  localparam int J_IDX_W_DEFAULT = 13;

endpackage

// File: rtl/j_img_index_counter_if.sv
// Control/status bundle between the image-fetch controller (master) and the index counter (slave).
// Carries lin_addr only when J_LINEAR_ADDR_EN is defined.
interface j_img_index_counter_if
  import j_img_pkg::*;
#(
  parameter int IDX_W  = J_IDX_W_DEFAULT,
  parameter int ADDR_W = 2 * IDX_W
);

  logic             clear;
  logic             start;
  logic [IDX_W-1:0] img_width;
  logic [IDX_W-1:0] img_height;
  logic             count_enable;
  logic [IDX_W-1:0] col;
  logic [IDX_W-1:0] row;
  logic             line_end;
  logic             frame_done;
  logic             busy;
  logic             cfg_err;
`ifdef J_LINEAR_ADDR_EN
  logic [ADDR_W-1:0] lin_addr;

  modport master (output clear, start, img_width, img_height, count_enable,
                  input  col, row, line_end, frame_done, busy, cfg_err, lin_addr);
  modport slave  (input  clear, start, img_width, img_height, count_enable,
                  output col, row, line_end, frame_done, busy, cfg_err, lin_addr);
`else
  modport master (output clear, start, img_width, img_height, count_enable,
                  input  col, row, line_end, frame_done, busy, cfg_err);
  modport slave  (input  clear, start, img_width, img_height, count_enable,
                  output col, row, line_end, frame_done, busy, cfg_err);
`endif

endinterface

// File: rtl/j_img_index_counter_rollover.sv
// Up-counter that returns to 0 after reaching rollover_val; wrap is combinational so
// a second instance can be chained off it in the same cycle.
module j_rollover_counter #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] value_q, value_d;

  assign wrap = count_enable && (value_q == rollover_val);

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (count_enable) begin
      value_d = wrap ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/j_img_index_counter.sv
// Frame-level raster index generator: column counter chained into a row counter under an IDLE/RUN/DONE FSM.
// Define J_LINEAR_ADDR_EN to add the incrementally maintained linear pixel address output.
module j_img_index_counter
  import j_img_pkg::*;
#(
  parameter int IDX_W  = J_IDX_W_DEFAULT,
  parameter int ADDR_W = 2 * IDX_W
) (
  input  logic                   clk,
  input  logic                   n_rst,
  j_img_index_counter_if.slave   bus
);

  j_idx_state_t     state_q, state_d;
  logic [IDX_W-1:0] wmax_q, wmax_d;
  logic [IDX_W-1:0] hmax_q, hmax_d;
  logic             line_end_q, line_end_d;
  logic             frame_done_q, frame_done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             cfg_ok;
  logic             start_accept;
  logic             cnt_clear;
  logic             pix_en;
  logic             col_wrap;
  logic             row_wrap;
  logic [IDX_W-1:0] col_val;
  logic [IDX_W-1:0] row_val;

  assign cfg_ok       = (bus.img_width != '0) && (bus.img_height != '0);
  assign start_accept = (state_q == IDLE) && bus.start && cfg_ok && !bus.clear;
  assign cnt_clear    = bus.clear || start_accept;
  assign pix_en       = (state_q == RUN) && bus.count_enable && !bus.clear;

  // Row advances only on a column wrap, so a row wrap marks the last pixel of the frame.
  j_rollover_counter #(.W(IDX_W)) u_col (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (pix_en),
    .rollover_val (wmax_q),
    .value        (col_val),
    .wrap         (col_wrap)
  );

  j_rollover_counter #(.W(IDX_W)) u_row (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (col_wrap),
    .rollover_val (hmax_q),
    .value        (row_val),
    .wrap         (row_wrap)
  );

  always_comb begin
    state_d      = state_q;
    wmax_d       = wmax_q;
    hmax_d       = hmax_q;
    line_end_d   = col_wrap;
    frame_done_d = row_wrap;
    cfg_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            wmax_d  = bus.img_width - 1'b1;
            hmax_d  = bus.img_height - 1'b1;
            state_d = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN:     if (row_wrap) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.clear) begin
      state_d      = IDLE;
      wmax_d       = '0;
      hmax_d       = '0;
      line_end_d   = 1'b0;
      frame_done_d = 1'b0;
      cfg_err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      wmax_q       <= '0;
      hmax_q       <= '0;
      line_end_q   <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wmax_q       <= wmax_d;
      hmax_q       <= hmax_d;
      line_end_q   <= line_end_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign bus.col        = col_val;
  assign bus.row        = row_val;
  assign bus.line_end   = line_end_q;
  assign bus.frame_done = frame_done_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.busy       = (state_q == RUN);

`ifdef J_LINEAR_ADDR_EN
  // Tracks row*width+col by counting pixels, avoiding a multiplier.
  logic [ADDR_W-1:0] lin_q, lin_d;

  always_comb begin
    lin_d = lin_q;
    if (cnt_clear) begin
      lin_d = '0;
    end else if (pix_en) begin
      lin_d = row_wrap ? '0 : lin_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lin_q <= '0;
    end else begin
      lin_q <= lin_d;
    end
  end

  assign bus.lin_addr = lin_q;
`endif

endmodule

// File: tb/tb_j_img_index_counter.sv
// Self-checking bench for j_img_index_counter: vector table, directed corner sequences and a randomized
// run against a pixel-count reference model. Checks lin_addr when J_LINEAR_ADDR_EN is defined.
module tb_j_img_index_counter;

  localparam int IDX_W = 13;

  logic clk;
  logic n_rst;
  int   testsRun;
  int   failures;

  // Reference model: frame progress held as a pixel count, outputs derived arithmetically.
  int   mState;
  int   mW, mH, mP;
  logic mLe, mFd, mErr;

  typedef struct {
    logic clr;
    logic st;
    int   w;
    int   h;
    logic en;
    int   eCol;
    int   eRow;
    logic eLe;
    logic eFd;
    logic eBusy;
    logic eErr;
  } vec_t;

  vec_t tbl[13];

  j_img_index_counter_if #(.IDX_W(IDX_W)) bus ();

  j_img_index_counter #(.IDX_W(IDX_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    mState = 0; mW = 0; mH = 0; mP = 0;
    mLe = 1'b0; mFd = 1'b0; mErr = 1'b0;
  endtask

  task automatic modelStep(input logic clr, input logic st, input int w, input int h, input logic en);
    mLe = 1'b0; mFd = 1'b0; mErr = 1'b0;
    if (clr) begin
      modelReset();
    end else begin
      case (mState)
        0: if (st) begin
             if (w != 0 && h != 0) begin
               mW = w; mH = h; mP = 0; mState = 1;
             end else begin
               mErr = 1'b1;
             end
           end
        1: if (en) begin
             mP = mP + 1;
             if (mP % mW == 0) mLe = 1'b1;
             if (mP == mW * mH) begin
               mFd = 1'b1; mP = 0; mState = 2;
             end
           end
        default: mState = 0;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic st, input int w, input int h, input logic en);
    bus.clear        = clr;
    bus.start        = st;
    bus.img_width    = w[IDX_W-1:0];
    bus.img_height   = h[IDX_W-1:0];
    bus.count_enable = en;
    @(posedge clk);
    modelStep(clr, st, w, h, en);
    #1;
  endtask

  task automatic checkOutput(input string name, input int eCol, input int eRow,
                             input logic eLe, input logic eFd, input logic eBusy, input logic eErr);
    testsRun++;
    if (int'(bus.col) != eCol || int'(bus.row) != eRow || bus.line_end !== eLe ||
        bus.frame_done !== eFd || bus.busy !== eBusy || bus.cfg_err !== eErr) begin
      failures++;
      $display("[TB] FAIL %s: got col=%0d row=%0d le=%b fd=%b busy=%b err=%b, want col=%0d row=%0d le=%b fd=%b busy=%b err=%b",
               name, bus.col, bus.row, bus.line_end, bus.frame_done, bus.busy, bus.cfg_err,
               eCol, eRow, eLe, eFd, eBusy, eErr);
    end
  endtask

  task automatic checkLin(input string name, input int eLin);
`ifdef J_LINEAR_ADDR_EN
    testsRun++;
    if (int'(bus.lin_addr) != eLin) begin
      failures++;
      $display("[TB] FAIL %s lin_addr: got %0d want %0d", name, bus.lin_addr, eLin);
    end
`else
    if (eLin < 0) $display("[TB] note: negative address request for %s", name);
`endif
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, (mW == 0) ? 0 : mP % mW, (mW == 0) ? 0 : mP / mW,
                mLe, mFd, (mState == 1), mErr);
    checkLin(name, mP);
  endtask

  initial begin
    testsRun = 0;
    failures = 0;
    modelReset();
    n_rst            = 1'b0;
    bus.clear        = 1'b0;
    bus.start        = 1'b0;
    bus.img_width    = '0;
    bus.img_height   = '0;
    bus.count_enable = 1'b0;
    #3;
    checkOutput("reset", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkLin("reset", 0);
    #5 n_rst = 1'b1;

    // Table: W=3,H=2 frame, start-in-RUN/DONE ignored, cfg_err, clear beats enable.
    tbl[0]  = '{1'b0, 1'b1, 3, 2, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 0, 0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 0, 0, 1'b1, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 0, 0, 1'b0, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 0, 0, 1'b1, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 5, 5, 1'b1, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 0, 0, 1'b1, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 0, 0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 2, 2, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 0, 5, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 0, 0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 2, 1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 0, 0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].clr, tbl[i].st, tbl[i].w, tbl[i].h, tbl[i].en);
      checkOutput($sformatf("table[%0d]", i), tbl[i].eCol, tbl[i].eRow,
                  tbl[i].eLe, tbl[i].eFd, tbl[i].eBusy, tbl[i].eErr);
    end

    // Full frame W=10,H=4 with an enable every 4th cycle.
    applyStimulus(1'b0, 1'b1, 10, 4, 1'b0);
    checkOutput("frame start", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
      checkOutput($sformatf("frame en%0d", k), k % 10, (k % 40) / 10,
                  (k % 10 == 0), (k == 40), (k < 40), 1'b0);
      checkLin("frame", k % 40);
      for (int g = 0; g < 3; g++) begin
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
        checkOutput($sformatf("frame gap%0d", k), k % 10, (k % 40) / 10, 1'b0, 1'b0, (k < 40), 1'b0);
      end
    end

    // Asynchronous reset in the middle of a frame.
    applyStimulus(1'b0, 1'b1, 10, 4, 1'b0);
    for (int k = 0; k < 13; k++) applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    checkOutput("pre-reset", 3, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    modelReset();
    checkOutput("async reset", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkLin("async reset", 0);
    #1 n_rst = 1'b1;

    // Degenerate 1x1 frame.
    applyStimulus(1'b0, 1'b1, 1, 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    checkOutput("1x1 enable", 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("1x1 after", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Rejected start with zero width.
    applyStimulus(1'b0, 1'b1, 0, 5, 1'b0);
    checkOutput("cfg_err pulse", 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 5, 1'b1);
    checkOutput("cfg_err drop", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 5, 1'b1);
    checkOutput("cfg_err idle en", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clear together with enable at col=57.
    applyStimulus(1'b0, 1'b1, 100, 3, 1'b0);
    for (int k = 0; k < 57; k++) applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    checkOutput("col57", 57, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
    checkOutput("clear+en", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkLin("clear+en", 0);

    // Maximum width 8191, two rows.
    applyStimulus(1'b0, 1'b1, 8191, 2, 1'b0);
    for (int k = 0; k < 8190; k++) applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    checkOutput("max col8190", 8190, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    checkOutput("max wrap", 0, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkLin("max wrap", 8191);
    checkModel("max model");
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    checkModel("max clear");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 1) == 1);
      checkModel("random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
